// File: rtl/pending_prio_encoder_pkg.sv
// Shared constants and width helper for the pending priority encoder slice.
package pending_prio_encoder_pkg;

  localparam int unsigned PE_DEF_N = 16;

  function automatic int unsigned pe_clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pending_prio_encoder_if.sv
// Request/mask inputs and valid/ready index output of the pending priority encoder.
interface pending_prio_encoder_if
  import pending_prio_encoder_pkg::*;
#(
  parameter int unsigned N = PE_DEF_N
);

  localparam int unsigned IDX_W = pe_clog2(N);

  logic [N-1:0]     req_i;
  logic [N-1:0]     mask_i;
  logic             mode_i;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pending_o;
  logic             busy_o;

  modport master (
    output req_i, mask_i, mode_i, out_ready,
    input  out_valid, out_idx, pending_o, busy_o
  );

  modport slave (
    input  req_i, mask_i, mode_i, out_ready,
    output out_valid, out_idx, pending_o, busy_o
  );

endinterface

// File: rtl/pending_prio_encoder_prio_pick.sv
// Combinational highest-set-bit picker with optional round-robin start point.
module prio_pick #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start_ptr,
  input  logic             rr_en,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

  logic [IDX_W-1:0] w_shift;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_hit;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_wrap;
  logic             w_unused;

  // Rotate so bit (start-1) lands on the top position; scan then runs downward from there.
  assign w_shift  = rr_en ? start_ptr : '0;
  assign w_dbl    = {vec, vec} >> w_shift;
  assign w_rot    = w_dbl[N-1:0];
  assign w_unused = ^w_dbl[2*N-1:N];

  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_rot[i]) w_hit = i[IDX_W-1:0];
    end
  end

  assign w_sum  = {1'b0, w_hit} + {1'b0, w_shift};
  assign w_wrap = w_sum - N_W;
  assign idx    = (w_sum >= N_W) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];
  assign any    = |vec;

endmodule

// File: rtl/pending_prio_encoder.sv
// Sticky pending register with masked fixed/round-robin selection on a valid/ready output.
module pending_prio_encoder
  import pending_prio_encoder_pkg::*;
#(
  parameter int unsigned N = PE_DEF_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pending_prio_encoder_if.slave bus
);

  localparam int unsigned IDX_W = pe_clog2(N);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]       r_state;
  logic [N-1:0]     r_pending;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_grant;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_elig;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;

  assign w_grant = (r_state == S_OFFER) && bus.out_ready;
  assign w_clr   = w_grant ? ({{(N-1){1'b0}}, 1'b1} << r_idx) : '0;
  assign w_elig  = r_pending & bus.mask_i & ~w_clr;
  // A back-to-back pick must scan from the index being granted right now, not the stale pointer.
  assign w_start = w_grant ? r_idx : r_rr_ptr;

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec       (w_elig),
    .start_ptr (w_start),
    .rr_en     (bus.mode_i),
    .idx       (w_pick),
    .any       (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_idx     <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.req_i;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_OFFER;
            r_idx   <= w_pick;
          end
        end
        S_OFFER: begin
          if (bus.out_ready) begin
            r_rr_ptr <= r_idx;
            if (w_any) r_idx   <= w_pick;
            else       r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.out_valid = (r_state == S_OFFER);
  assign bus.out_idx   = r_idx;
  assign bus.pending_o = r_pending;
  assign bus.busy_o    = |(r_pending & bus.mask_i);

endmodule

// File: tb/tb_pending_prio_encoder.sv
// Directed scoreboard bench for pending_prio_encoder (N=16).
module tb_pending_prio_encoder;

  logic clk;
  logic rst_n;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned exp_q[$];

  pending_prio_encoder_if #(.N(16)) bus ();

  pending_prio_encoder #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs are driven just after a negedge; a handshake seen here completes on the coming posedge.
  task automatic cyc();
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL grant_unexpected observed=%0h expected=none", bus.out_idx);
      end else begin
        chk("grant_idx", 64'(bus.out_idx), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && exp_q.size() != 0; i++) cyc();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL drain_timeout observed=%0d_left expected=0_left", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    rst_n       = 1'b1;
    bus.req_i     = '0;
    bus.mask_i    = 16'hFFFF;
    bus.mode_i    = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid",   64'(bus.out_valid), 64'd0);
    chk("rst_idx",     64'(bus.out_idx),   64'd0);
    chk("rst_pending", 64'(bus.pending_o), 64'd0);
    chk("rst_busy",    64'(bus.busy_o),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fixed priority, two simultaneous requests
    bus.req_i = 16'h8001; exp_q.push_back(15); exp_q.push_back(0);
    cyc();
    bus.req_i = '0;
    drain(8);
    chk("t1_valid",   64'(bus.out_valid), 64'd0);
    chk("t1_pending", 64'(bus.pending_o), 64'd0);

    // 2: round-robin sweep, then wrap back to the top
    bus.mode_i = 1'b1;
    bus.req_i = 16'h8421;
    exp_q.push_back(15); exp_q.push_back(10); exp_q.push_back(5); exp_q.push_back(0);
    cyc();
    bus.req_i = '0;
    drain(10);
    bus.req_i = 16'h8421;
    exp_q.push_back(15); exp_q.push_back(10); exp_q.push_back(5); exp_q.push_back(0);
    cyc();
    bus.req_i = '0;
    drain(10);
    bus.mode_i = 1'b0;

    // 3: backpressure holds the offer against new requests, mask drop and mode change
    bus.out_ready = 1'b0;
    bus.req_i = 16'h0008;
    cyc();
    bus.req_i = '0;
    cyc();
    chk("t3_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_idx",   64'(bus.out_idx),   64'd3);
    bus.req_i = 16'h1000;
    cyc();
    bus.req_i = '0;
    cyc();
    chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_hold_idx",   64'(bus.out_idx),   64'd3);
    chk("t3_pending",    64'(bus.pending_o), 64'h1008);
    bus.mask_i = '0;
    bus.mode_i = 1'b1;
    cyc();
    chk("t3_mask_idx",  64'(bus.out_idx), 64'd3);
    chk("t3_mask_busy", 64'(bus.busy_o),  64'd0);
    bus.mask_i = 16'hFFFF;
    bus.mode_i = 1'b0;
    exp_q.push_back(3); exp_q.push_back(12);
    bus.out_ready = 1'b1;
    drain(8);
    chk("t3_idle", 64'(bus.out_valid), 64'd0);

    // 4: request on the granted bit in the handshake cycle survives
    bus.req_i = 16'h8000; exp_q.push_back(15);
    cyc();
    bus.req_i = '0;
    cyc();
    chk("t4_offer", 64'(bus.out_idx), 64'd15);
    bus.req_i = 16'h8000; exp_q.push_back(15);
    cyc();
    bus.req_i = '0;
    chk("t4_pending", 64'(bus.pending_o), 64'h8000);
    chk("t4_gap",     64'(bus.out_valid), 64'd0);
    drain(8);
    chk("t4_clear", 64'(bus.pending_o), 64'd0);

    // 5: masked bit accumulates, selectable once unmasked
    bus.mask_i = 16'h7FFF;
    bus.req_i = 16'h8008; exp_q.push_back(3);
    cyc();
    bus.req_i = '0;
    drain(8);
    chk("t5_busy",    64'(bus.busy_o),    64'd0);
    chk("t5_pending", 64'(bus.pending_o), 64'h8000);
    chk("t5_valid",   64'(bus.out_valid), 64'd0);
    bus.mask_i = 16'hFFFF;
    #1;
    chk("t5_busy_unmask", 64'(bus.busy_o), 64'd1);
    exp_q.push_back(15);
    cyc();
    chk("t5_offer_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_offer_idx",   64'(bus.out_idx),   64'd15);
    drain(8);

    // 6: asynchronous reset during an offer
    bus.out_ready = 1'b0;
    bus.req_i = 16'h0040;
    cyc();
    bus.req_i = '0;
    cyc();
    chk("t6_offer", 64'(bus.out_idx), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",   64'(bus.out_valid), 64'd0);
    chk("t6_rst_pending", 64'(bus.pending_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      cyc();
      chk("t6_quiet", 64'(bus.out_valid), 64'd0);
    end
    bus.req_i = 16'h0002; exp_q.push_back(1);
    cyc();
    bus.req_i = '0;
    drain(8);
    chk("t6_end_pending", 64'(bus.pending_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pending_prio_encoder.md
Name: pending_prio_encoder

Overview:
Parametrised, registered successor to the 16-input combinational priority encoder. It latches request pulses into a sticky pending register and applies a per-bit mask. It selects one pending index per grant, using either fixed highest-index-first priority or round-robin priority. The index is presented on a valid/ready output so a downstream consumer (interrupt/event dispatcher behind the TT wrapper) can service one event per cycle.

Parameters:
N, 16, number of request lines (2..64).
IDX_W, $clog2(N), width of the index output. Derived localparam; not overridable.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  N  request pulses/levels; bit k high in a cycle sets pending[k]
mask_i  input  N  1 = bit eligible for selection; does not affect capture
mode_i  input  1  0 = fixed priority (highest index wins), 1 = round-robin
out_ready  input  1  consumer accepts out_idx this cycle
out_valid  output  1  out_idx holds a selected pending index
out_idx  output  IDX_W  selected index, binary
pending_o  output  N  current pending register, unmasked
busy_o  output  1  |(pending & mask_i), combinational from register + mask

Behaviour:
- Reset (async assert, sync release): pending=0, out_valid=0, out_idx=0, rr_ptr=0. Reset during an offer drops the offer; no grant is lost or duplicated afterwards, because pending is also cleared.
- Capture, every edge: pending <= (pending & ~clr) | req_i. clr = onehot(out_idx) when out_valid & out_ready, else 0. Set wins over clear: a req on the granted bit in the handshake cycle leaves it pending.
- Eligible vector: elig = pending & mask_i & ~clr. Selection never looks at the current-cycle req_i.
- Selection, fixed mode: highest set bit of elig.
- Selection, round-robin mode: scan descending from rr_ptr-1, wrapping from 0 to N-1; rr_ptr is the last granted index. With rr_ptr=0 the scan starts at N-1, so RR matches fixed priority right after reset.
- Two states, IDLE (out_valid=0) and OFFER (out_valid=1).
- IDLE: if elig!=0 -> OFFER, out_idx <= pick(elig). Otherwise stay IDLE.
- OFFER, out_ready=0: out_idx and out_valid held stable, even if mask_i drops the bit or a higher-priority request arrives (AXI-style stability).
- OFFER, out_ready=1: grant. rr_ptr <= out_idx in both modes. If elig!=0, stay in OFFER and load the new pick the same edge (back-to-back, 1 grant/cycle). Else -> IDLE.
- Latency: req_i high at edge t -> pending at t -> out_valid at t+1 (one cycle from pending to offer), when the block is IDLE and the bit is eligible.
- mode_i is sampled only when a pick is loaded; changing it mid-offer has no effect on the current offer.
- No "all zeros" code: absence of a request is signalled by out_valid=0. out_idx is don't-care-stable (holds its last value) while IDLE.
- Bits with mask_i=0 still accumulate in pending and become selectable once unmasked.

Decomposition:
- Shared package: default N, and the IDX_W derivation function (clog2), reused by the wrapper.
- One combinational sub-module, prio_pick (N, IDX_W): inputs vec, start_ptr, rr_en; outputs idx and any. Implemented as a rotate, then a highest-set-bit search, then an un-rotate.
- FSM, pending register and rr_ptr live in the top.
- The TT wrapper instantiates the block with N=16: ui_in/uio_in feed req_i, uo_out[3:0]=out_idx, uo_out[7]=out_valid.

Test Plan:
1. Fixed mode, mask=all 1, ready=1; req_i=0x8001 for one cycle -> idx 15, then idx 0 on consecutive cycles; then out_valid=0, pending_o=0.
2. RR mode, req_i=0x8421 for one cycle, ready=1 -> grants 15, 10, 5, 0. Then re-pulse 0x8421 -> next grant is 15 (rr_ptr=0 wraps to N-1).
3. Backpressure: ready=0, offer idx 3; pulse req bit 12 -> out_idx stays 3 and out_valid stays 1. Raise ready -> 3 accepted, then 12 offered.
4. Set-wins: offer idx 15 with ready=1 and req_i[15]=1 in the same cycle -> pending_o[15] stays 1 and idx 15 is re-offered after the current grant cycle.
5. Mask: pending=0x8008, mask=0x7FFF -> idx 3 offered and granted, busy_o=0 while pending_o=0x8000. Set mask=0xFFFF -> idx 15 offered next cycle.
6. Reset mid-offer: rst_n low while out_valid=1 -> out_valid=0 and pending_o=0 immediately (async). After release, no offer appears until a new req_i arrives.
